slave_port: RTL and testbench

//  Bus-side receiver of the serial system bus, one per slave. Accepts a serial transaction from

---
 rtl/system_bus_pkg.sv | 36 +++
 rtl/serial_rx_shifter.sv | 40 ++++
 rtl/slave_port.sv | 191 +++++++++++++++++++
 tb/tb_slave_port.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/system_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : system_bus_pkg
// Description : Shared widths, state encoding and helpers for the serial bus.
// Revision    : 1.0 - initial release
// ============================================================================
package system_bus_pkg;

  localparam int c_ADDR_WIDTH  = 12;
  localparam int c_DATA_WIDTH  = 8;
  localparam int c_BURST_WIDTH = 13;

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_RX_HDR  = 3'd1;
  localparam logic [2:0] c_ST_WR_DATA = 3'd2;
  localparam logic [2:0] c_ST_WR_MEM  = 3'd3;
  localparam logic [2:0] c_ST_RD_MEM  = 3'd4;
  localparam logic [2:0] c_ST_RD_TX   = 3'd5;
  localparam logic [2:0] c_ST_DONE    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = c_ST_IDLE,
    ST_RX_HDR  = c_ST_RX_HDR,
    ST_WR_DATA = c_ST_WR_DATA,
    ST_WR_MEM  = c_ST_WR_MEM,
    ST_RD_MEM  = c_ST_RD_MEM,
    ST_RD_TX   = c_ST_RD_TX,
    ST_DONE    = c_ST_DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_rx_shifter.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx_shifter
// Description : LSB-first serial-in parallel-out shifter, shifts on enable.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_rx_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  generate
    if (WIDTH > 1) begin : g_multi
      assign w_next = {bit_in, r_q[WIDTH-1:1]};
    end else begin : g_single
      assign w_next = bit_in;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= '0;
    end else if (shift_en) begin
      r_q <= w_next;
    end
  end

  // Includes the bit arriving this cycle so the final bit is usable immediately.
  assign value = shift_en ? w_next : r_q;

endmodule
`default_nettype wire

// File: rtl/slave_port.sv
`default_nettype none
// ============================================================================
// Module      : slave_port
// Description : Serial bus slave; deserialises requests, drives local memory,
//               serialises read data back with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module slave_port
  import system_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = c_ADDR_WIDTH,
  parameter int DATA_WIDTH  = c_DATA_WIDTH,
  parameter int BURST_WIDTH = c_BURST_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  master_valid,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic                  rx_address,
  input  logic                  rx_burst_number,
  input  logic                  rx_data,
  input  logic                  master_ready,
  output logic                  slave_ready,
  output logic                  slave_valid,
  output logic                  tx_data,
  output logic                  slave_tx_done,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam int c_HDR_LEN = max_int(ADDR_WIDTH, BURST_WIDTH);
  localparam int c_CNT_W   = $clog2(max_int(c_HDR_LEN, DATA_WIDTH) + 1);

  localparam logic [c_CNT_W-1:0] c_HDR_LAST   = c_CNT_W'(c_HDR_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_DATA_LAST  = c_CNT_W'(DATA_WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ADDR_BITS  = c_CNT_W'(ADDR_WIDTH);
  localparam logic [c_CNT_W-1:0] c_BURST_BITS = c_CNT_W'(BURST_WIDTH);

  state_t                 r_state;
  logic                   r_is_write;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [BURST_WIDTH-1:0] r_words;
  logic [DATA_WIDTH-1:0]  r_tx_shift;

  logic                   w_start;
  logic                   w_hdr_bit;
  logic                   w_hdr_last;
  logic                   w_is_write;
  logic                   w_addr_shift;
  logic                   w_burst_shift;
  logic                   w_data_shift;
  logic                   w_last_word;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [BURST_WIDTH-1:0] w_burst;
  logic [DATA_WIDTH-1:0]  w_wdata;

  // The qualifying IDLE cycle already carries header bit 0.
  assign w_start       = (r_state == ST_IDLE) && master_valid && (write_en ^ read_en);
  assign w_hdr_bit     = w_start || ((r_state == ST_RX_HDR) && master_valid);
  assign w_hdr_last    = w_hdr_bit && (r_cnt == c_HDR_LAST);
  assign w_is_write    = (r_state == ST_IDLE) ? write_en : r_is_write;
  assign w_addr_shift  = w_hdr_bit && (r_cnt < c_ADDR_BITS);
  assign w_burst_shift = w_hdr_bit && (r_cnt < c_BURST_BITS);
  assign w_data_shift  = (r_state == ST_WR_DATA) && master_valid;
  assign w_last_word   = (r_words == '0);

  assign tx_data       = r_tx_shift[0];
  assign slave_tx_done = (r_state == ST_RD_TX) && master_ready && (r_cnt == c_DATA_LAST);

  serial_rx_shifter #(.WIDTH(ADDR_WIDTH)) u_addr_shifter (
    .clk(clk), .reset(reset), .shift_en(w_addr_shift), .bit_in(rx_address), .value(w_addr)
  );

  serial_rx_shifter #(.WIDTH(BURST_WIDTH)) u_burst_shifter (
    .clk(clk), .reset(reset), .shift_en(w_burst_shift), .bit_in(rx_burst_number), .value(w_burst)
  );

  serial_rx_shifter #(.WIDTH(DATA_WIDTH)) u_data_shifter (
    .clk(clk), .reset(reset), .shift_en(w_data_shift), .bit_in(rx_data), .value(w_wdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_is_write  <= 1'b0;
      r_cnt       <= '0;
      r_words     <= '0;
      r_tx_shift  <= '0;
      slave_ready <= 1'b1;
      slave_valid <= 1'b0;
      done        <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RX_HDR: begin
          if (w_hdr_bit) begin
            slave_ready <= 1'b0;
            r_is_write  <= w_is_write;
            if (w_hdr_last) begin
              r_cnt       <= '0;
              mem_address <= w_addr;
              r_words     <= w_burst;
              if (w_is_write) begin
                r_state <= ST_WR_DATA;
              end else begin
                r_state  <= ST_RD_MEM;
                mem_read <= 1'b1;
              end
            end else begin
              r_cnt   <= r_cnt + c_CNT_W'(1);
              r_state <= ST_RX_HDR;
            end
          end
        end
        ST_WR_DATA: begin
          if (w_data_shift) begin
            if (r_cnt == c_DATA_LAST) begin
              r_cnt     <= '0;
              mem_wdata <= w_wdata;
              mem_write <= 1'b1;
              r_state   <= ST_WR_MEM;
            end else begin
              r_cnt <= r_cnt + c_CNT_W'(1);
            end
          end
        end
        ST_WR_MEM: begin
          if (mem_ready) begin
            mem_write   <= 1'b0;
            mem_address <= mem_address + ADDR_WIDTH'(1);
            if (w_last_word) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
            end else begin
              r_words <= r_words - BURST_WIDTH'(1);
              r_state <= ST_WR_DATA;
            end
          end
        end
        ST_RD_MEM: begin
          if (mem_ready) begin
            mem_read    <= 1'b0;
            r_tx_shift  <= mem_rdata;
            slave_valid <= 1'b1;
            r_state     <= ST_RD_TX;
          end
        end
        ST_RD_TX: begin
          if (master_ready) begin
            // Zero fill leaves tx_data low once the word has been sent.
            r_tx_shift <= r_tx_shift >> 1;
            if (r_cnt == c_DATA_LAST) begin
              r_cnt       <= '0;
              slave_valid <= 1'b0;
              mem_address <= mem_address + ADDR_WIDTH'(1);
              if (w_last_word) begin
                r_state <= ST_DONE;
                done    <= 1'b1;
              end else begin
                r_words  <= r_words - BURST_WIDTH'(1);
                r_state  <= ST_RD_MEM;
                mem_read <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + c_CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          slave_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_slave_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_slave_port
// Description : Self-checking bench for slave_port with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slave_port;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int BW  = 13;
  localparam int HDR = 13;

  logic          clk = 1'b0;
  logic          reset, master_valid, write_en, read_en;
  logic          rx_address, rx_burst_number, rx_data, master_ready;
  logic          slave_ready, slave_valid, tx_data, slave_tx_done, done;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_write, mem_read;
  logic          mem_ready = 1'b0;

  always #5 clk = ~clk;

  slave_port dut (
    .clk(clk), .reset(reset), .master_valid(master_valid), .write_en(write_en),
    .read_en(read_en), .rx_address(rx_address), .rx_burst_number(rx_burst_number),
    .rx_data(rx_data), .master_ready(master_ready), .slave_ready(slave_ready),
    .slave_valid(slave_valid), .tx_data(tx_data), .slave_tx_done(slave_tx_done),
    .done(done), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  always @(posedge clk) cycle++;

  // Local memory model with programmable response latency.
  logic [DW-1:0] ref_mem [0:4095];
  assign mem_rdata = ref_mem[mem_address];
  int mem_lat  = 0;
  int wait_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (!reset || mem_ready) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end else if (mem_write || mem_read) begin
      if (wait_cnt >= mem_lat) mem_ready = 1'b1;
      else wait_cnt++;
    end
  end

  // Observed bus activity.
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  logic [AW-1:0] rd_q[$];
  logic          bit_q[$];
  int done_cnt = 0, done_cyc = 0, txd_cnt = 0, txd_cyc = 0, txd_bad = 0, ready_bad = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (mem_write && mem_ready) begin wa_q.push_back(mem_address); wd_q.push_back(mem_wdata); end
      if (mem_read && mem_ready) rd_q.push_back(mem_address);
      if (slave_valid && master_ready) begin
        bit_q.push_back(tx_data);
        if (slave_tx_done != ((bit_q.size() % DW) == 0)) txd_bad++;
      end
      if (slave_tx_done) begin txd_cnt++; txd_cyc = cycle; end
      if (prev_done && !slave_ready) ready_bad++;
      if (done) begin done_cnt++; done_cyc = cycle; end
      prev_done = done;
    end
  end

  logic [DW-1:0] wdata_arr [0:15];
  bit timed_out;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_header(input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] b,
                             input int stall_at, input bit rnd);
    write_en = wr;
    read_en  = !wr;
    for (int i = 0; i < HDR; i++) begin
      int st;
      st = (i == stall_at) ? 2 : (rnd ? int'($urandom_range(0, 1)) : 0);
      repeat (st) begin master_valid = 1'b0; rx_address = 1'($urandom); tick(); end
      master_valid = 1'b1;
      if (i < AW) rx_address = a[i];
      else rx_address = 1'($urandom);
      rx_burst_number = b[i];
      tick();
    end
    master_valid = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input int nbits, input bit rnd);
    for (int i = 0; i < nbits; i++) begin
      if (rnd) repeat ($urandom_range(0, 1)) begin master_valid = 1'b0; tick(); end
      master_valid = 1'b1;
      rx_data = d[i];
      tick();
    end
    master_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int t = 0;
    while (wa_q.size() < n && t < 200) begin tick(); t++; end
    if (wa_q.size() < n) timed_out = 1'b1;
  endtask

  task automatic recv_read(input int nbits, input int low_at, input bit rnd);
    int low_used = 0, t = 0;
    while (bit_q.size() < nbits && t < 2000) begin
      if (bit_q.size() == low_at && low_used < 2 && slave_valid) begin
        master_ready = 1'b0;
        low_used++;
      end else begin
        master_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      tick();
      t++;
    end
    if (bit_q.size() < nbits) timed_out = 1'b1;
    master_ready = 1'b0;
  endtask

  task automatic run_txn(input bit wr, input logic [AW-1:0] a, input int burst, input int stall_at,
                         input int low_at, input bit rnd, output int cycles);
    int start, t = 0, d0;
    wa_q.delete(); wd_q.delete(); rd_q.delete(); bit_q.delete();
    txd_bad = 0; txd_cnt = 0; ready_bad = 0; timed_out = 1'b0;
    d0 = done_cnt;
    while (!slave_ready && t < 100) begin tick(); t++; end
    start = cycle;
    send_header(wr, a, BW'(burst), stall_at, rnd);
    if (wr) begin
      for (int w = 0; w <= burst; w++) begin
        send_word(wdata_arr[w], DW, rnd);
        wait_writes(w + 1);
      end
    end else begin
      recv_read((burst + 1) * DW, low_at, rnd);
    end
    t = 0;
    while (done_cnt == d0 && t < 100) begin tick(); t++; end
    if (done_cnt != d0 + 1) timed_out = 1'b1;
    cycles = done_cyc - start;
    tick();
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({slave_ready, slave_valid, tx_data, slave_tx_done, done, mem_write, mem_read} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 1000000",
               {slave_ready, slave_valid, tx_data, slave_tx_done, done, mem_write, mem_read});
    end
    checks++;
    if ({mem_address, mem_wdata} !== 20'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h expected 00000", {mem_address, mem_wdata});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    int cyc;
    mem_lat = 0;
    wdata_arr[0] = 8'hBD;
    run_txn(1'b1, 12'hADD, 0, -1, -1, 1'b0, cyc);
    checks++;
    if (timed_out || wa_q.size() != 1 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL sw_count: timeout=%0d writes=%0d reads=%0d expected 0/1/0", timed_out, wa_q.size(), rd_q.size());
    end else begin
      checks++;
      if ({wa_q[0], wd_q[0]} !== {12'hADD, 8'hBD}) begin
        errors++;
        $display("FAIL sw_data: got %h/%h expected ADD/BD", wa_q[0], wd_q[0]);
      end
    end
    checks++;
    if (cyc != HDR + DW + 1) begin
      errors++;
      $display("FAIL sw_latency: got %0d expected %0d", cyc, HDR + DW + 1);
    end
    checks++;
    if (ready_bad != 0 || slave_ready !== 1'b1) begin
      errors++;
      $display("FAIL sw_ready: bad=%0d ready=%b expected 0/1", ready_bad, slave_ready);
    end
    ref_mem[12'hADD] = 8'hBD;
  endtask

  task automatic test_wrap_write();
    int cyc;
    logic [AW-1:0] ea;
    mem_lat = $urandom_range(0, 2);
    wdata_arr[0] = 8'h11; wdata_arr[1] = 8'h22; wdata_arr[2] = 8'h33;
    run_txn(1'b1, 12'hFFF, 2, -1, -1, 1'b0, cyc);
    checks++;
    if (timed_out || wa_q.size() != 3) begin
      errors++;
      $display("FAIL wrap_count: timeout=%0d writes=%0d expected 0/3", timed_out, wa_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        ea = AW'(12'hFFF + i);
        checks++;
        if ({wa_q[i], wd_q[i]} !== {ea, wdata_arr[i]}) begin
          errors++;
          $display("FAIL wrap_word%0d: got %h/%h expected %h/%h", i, wa_q[i], wd_q[i], ea, wdata_arr[i]);
        end
        ref_mem[ea] = wdata_arr[i];
      end
    end
  endtask

  task automatic test_read();
    int cyc;
    logic [7:0] pat;
    pat = 8'b1011_1101;
    mem_lat = 3;
    ref_mem[12'h010] = 8'hBD;
    run_txn(1'b0, 12'h010, 0, -1, -1, 1'b0, cyc);
    checks++;
    if (timed_out || bit_q.size() != DW || rd_q.size() != 1) begin
      errors++;
      $display("FAIL rd_count: timeout=%0d bits=%0d reads=%0d expected 0/8/1", timed_out, bit_q.size(), rd_q.size());
    end else begin
      checks++;
      if (rd_q[0] !== 12'h010) begin
        errors++;
        $display("FAIL rd_addr: got %h expected 010", rd_q[0]);
      end
      for (int i = 0; i < DW; i++) begin
        checks++;
        if (bit_q[i] !== pat[i]) begin
          errors++;
          $display("FAIL rd_bit%0d: got %b expected %b", i, bit_q[i], pat[i]);
        end
      end
    end
    checks++;
    if (txd_cnt != 1 || txd_bad != 0 || done_cyc != txd_cyc + 1) begin
      errors++;
      $display("FAIL rd_pulses: txd=%0d bad=%0d done_gap=%0d expected 1/0/1", txd_cnt, txd_bad, done_cyc - txd_cyc);
    end
  endtask

  task automatic test_stalls();
    int c[3];
    logic [AW-1:0] a;
    a = AW'($urandom);
    mem_lat = 1;
    for (int k = 0; k < 3; k++) begin
      run_txn(1'b0, a, 1, (k == 1) ? 5 : -1, (k == 2) ? 3 : -1, 1'b0, c[k]);
      checks++;
      if (timed_out || bit_q.size() != 2 * DW || rd_q.size() != 2) begin
        errors++;
        $display("FAIL stall%0d_count: timeout=%0d bits=%0d reads=%0d", k, timed_out, bit_q.size(), rd_q.size());
      end else begin
        for (int w = 0; w < 2; w++) begin
          logic [DW-1:0] got, exp;
          for (int b = 0; b < DW; b++) got[b] = bit_q[w * DW + b];
          exp = ref_mem[AW'(a + w)];
          checks++;
          if (got !== exp || rd_q[w] !== AW'(a + w)) begin
            errors++;
            $display("FAIL stall%0d_word%0d: got %h@%h expected %h@%h", k, w, got, rd_q[w], exp, AW'(a + w));
          end
        end
      end
    end
    checks++;
    if (c[1] != c[0] + 2 || c[2] != c[0] + 2) begin
      errors++;
      $display("FAIL stall_delay: got +%0d/+%0d expected +2/+2", c[1] - c[0], c[2] - c[0]);
    end
  endtask

  task automatic test_reset_abort();
    mem_lat = 0;
    wa_q.delete(); wd_q.delete(); timed_out = 1'b0;
    send_header(1'b1, 12'h123, 13'd3, -1, 1'b0);
    send_word(8'h5A, DW, 1'b0);
    wait_writes(1);
    send_word(8'hC3, 3, 1'b0);
    reset = 1'b0;
    master_valid = 1'b0;
    write_en = 1'b0;
    tick();
    checks++;
    if ({slave_ready, slave_valid, tx_data, slave_tx_done, done, mem_write, mem_read, mem_address, mem_wdata}
        !== {7'b1000000, 20'h0}) begin
      errors++;
      $display("FAIL abort_outputs: got %b/%h expected 1000000/00000",
               {slave_ready, slave_valid, tx_data, slave_tx_done, done, mem_write, mem_read}, {mem_address, mem_wdata});
    end
    reset = 1'b1;
    repeat (40) tick();
    checks++;
    if (timed_out || wa_q.size() != 1 || slave_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_nowrite: timeout=%0d writes=%0d ready=%b expected 0/1/1", timed_out, wa_q.size(), slave_ready);
    end
  endtask

  task automatic test_bad_enables();
    int bad = 0, d0;
    d0 = done_cnt;
    wa_q.delete(); wd_q.delete(); rd_q.delete();
    for (int k = 0; k < 2; k++) begin
      write_en = (k == 0);
      read_en  = (k == 0);
      for (int i = 0; i < 30; i++) begin
        master_valid = 1'b1;
        rx_address = 1'($urandom); rx_burst_number = 1'($urandom); rx_data = 1'($urandom);
        tick();
        if (!slave_ready || mem_write || mem_read) bad++;
      end
    end
    master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0;
    repeat (5) tick();
    checks++;
    if (bad != 0 || wa_q.size() != 0 || rd_q.size() != 0 || done_cnt != d0) begin
      errors++;
      $display("FAIL bad_enables: busy=%0d writes=%0d reads=%0d dones=%0d expected 0/0/0/0",
               bad, wa_q.size(), rd_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_random();
    int cyc, burst;
    bit wr;
    logic [AW-1:0] a, ea;
    for (int n = 0; n < 12; n++) begin
      wr = 1'($urandom);
      a = AW'($urandom);
      burst = $urandom_range(0, 3);
      mem_lat = $urandom_range(0, 3);
      for (int w = 0; w <= burst; w++) wdata_arr[w] = DW'($urandom);
      run_txn(wr, a, burst, -1, -1, 1'b1, cyc);
      checks++;
      if (timed_out || (wr ? (wa_q.size() != burst + 1) : (bit_q.size() != (burst + 1) * DW || rd_q.size() != burst + 1))
          || ready_bad != 0 || txd_bad != 0) begin
        errors++;
        $display("FAIL rnd%0d_shape: wr=%0d timeout=%0d writes=%0d reads=%0d bits=%0d burst=%0d",
                 n, wr, timed_out, wa_q.size(), rd_q.size(), bit_q.size(), burst);
      end else begin
        for (int w = 0; w <= burst; w++) begin
          logic [DW-1:0] got, exp;
          logic [AW-1:0] gaddr;
          ea = AW'(a + w);
          if (wr) begin
            got = wd_q[w]; gaddr = wa_q[w]; exp = wdata_arr[w];
          end else begin
            for (int b = 0; b < DW; b++) got[b] = bit_q[w * DW + b];
            gaddr = rd_q[w]; exp = ref_mem[ea];
          end
          checks++;
          if (got !== exp || gaddr !== ea) begin
            errors++;
            $display("FAIL rnd%0d_word%0d: got %h@%h expected %h@%h", n, w, got, gaddr, exp, ea);
          end
          if (wr) ref_mem[ea] = wdata_arr[w];
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0;
    rx_address = 1'b0; rx_burst_number = 1'b0; rx_data = 1'b0; master_ready = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = DW'($urandom);
    test_reset();
    test_single_write();
    test_wrap_write();
    test_read();
    test_stalls();
    test_reset_abort();
    test_bad_enables();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
